// File: rtl/store_pkg.sv
// Shared store/load constants, the fault record payload and the store-data lane replication helper.
package store_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned F3_W   = 3;

  localparam logic [F3_W-1:0] FUNCT3_SB = 3'b000;
  localparam logic [F3_W-1:0] FUNCT3_SH = 3'b001;
  localparam logic [F3_W-1:0] FUNCT3_SW = 3'b010;

  localparam logic CAUSE_MISALIGNED = 1'b0;
  localparam logic CAUSE_ILLEGAL    = 1'b1;

  typedef struct packed {
    logic              cause;
    logic [F3_W-1:0]   funct3;
    logic [ADDR_W-1:0] addr;
  } fault_rec_t;

  // Narrow stores are copied onto every lane so the byte enables alone pick the target.
  function automatic logic [DATA_W-1:0] replicate_store_data(input logic [F3_W-1:0]   funct3,
                                                              input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] res;
    case (funct3)
      FUNCT3_SB: res = {4{data[7:0]}};
      FUNCT3_SH: res = {2{data[15:0]}};
      default:   res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/store_unit_if.sv
// Execute-stage to store-unit bus: store request in, lane controls and fault record out.
interface store_unit_if;
  import store_pkg::*;

  logic [F3_W-1:0]   funct3_i;
  logic              mem_write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] store_data_i;
  logic              fault_clr_i;
  logic [BE_W-1:0]   write_en_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              misaligned_o;
  logic              illegal_o;
  logic              fault_o;
  logic              fault_cause_o;
  logic [F3_W-1:0]   fault_funct3_o;
  logic [ADDR_W-1:0] fault_addr_o;

  modport master (
    output funct3_i, mem_write_i, addr_i, store_data_i, fault_clr_i,
    input  write_en_o, mem_wdata_o, misaligned_o, illegal_o,
           fault_o, fault_cause_o, fault_funct3_o, fault_addr_o
  );

  modport slave (
    input  funct3_i, mem_write_i, addr_i, store_data_i, fault_clr_i,
    output write_en_o, mem_wdata_o, misaligned_o, illegal_o,
           fault_o, fault_cause_o, fault_funct3_o, fault_addr_o
  );

endinterface

// File: rtl/store_be_decode.sv
// Combinational byte-enable decode with misaligned/illegal classification of a store.
module store_be_decode
  import store_pkg::*;
(
  input  logic [F3_W-1:0]   funct3_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [BE_W-1:0]   write_en_o,
  output logic              misaligned_o,
  output logic              illegal_o
);

  always_comb begin
    write_en_o   = '0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    if (mem_write_i) begin
      case (funct3_i)
        FUNCT3_SB: write_en_o = BE_W'(4'b0001 << addr_i);
        FUNCT3_SH: begin
          if (addr_i[0]) misaligned_o = 1'b1;
          else           write_en_o   = addr_i[1] ? 4'b1100 : 4'b0011;
        end
        FUNCT3_SW: begin
          if (addr_i == 2'b00) write_en_o   = 4'b1111;
          else                 misaligned_o = 1'b1;
        end
        default:   illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/store_unit.sv
// Store-path byte-lane unit: lane enables, data replication, reset gating and a sticky first-fault record.
module store_unit
  import store_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  store_unit_if.slave  bus
);

  logic [BE_W-1:0] dec_write_en;
  logic            dec_misaligned;
  logic            dec_illegal;
  logic            capture;

  logic            fault_valid_d, fault_valid_q;
  fault_rec_t      fault_rec_d,   fault_rec_q;

  store_be_decode u_be_decode (
    .funct3_i     (bus.funct3_i),
    .mem_write_i  (bus.mem_write_i),
    .addr_i       (bus.addr_i),
    .write_en_o   (dec_write_en),
    .misaligned_o (dec_misaligned),
    .illegal_o    (dec_illegal)
  );

  assign bus.write_en_o   = rst_ni ? dec_write_en : '0;
  assign bus.misaligned_o = rst_ni & dec_misaligned;
  assign bus.illegal_o    = rst_ni & dec_illegal;
  assign bus.mem_wdata_o  = replicate_store_data(bus.funct3_i, bus.store_data_i);

  // A clear in the same cycle as a new fault still records it, so no event is dropped.
  assign capture = (dec_misaligned | dec_illegal) & (~fault_valid_q | bus.fault_clr_i);

  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_rec_d   = fault_rec_q;
    if (bus.fault_clr_i) fault_valid_d = 1'b0;
    if (capture) begin
      fault_valid_d      = 1'b1;
      fault_rec_d.cause  = dec_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
      fault_rec_d.funct3 = bus.funct3_i;
      fault_rec_d.addr   = bus.addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fault_valid_q <= 1'b0;
      fault_rec_q   <= '0;
    end else begin
      fault_valid_q <= fault_valid_d;
      fault_rec_q   <= fault_rec_d;
    end
  end

  assign bus.fault_o        = fault_valid_q;
  assign bus.fault_cause_o  = fault_rec_q.cause;
  assign bus.fault_funct3_o = fault_rec_q.funct3;
  assign bus.fault_addr_o   = fault_rec_q.addr;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: vector table for the combinational path, queued fault-record expectations.
module tb_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  store_unit_if bus ();

  store_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        rst_n;
    logic [2:0]  f3;
    logic        mw;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        clr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        mis;
    logic        ill;
  } vec_t;

  typedef struct {
    logic       valid;
    logic       cause;
    logic [2:0] f3;
    logic [1:0] addr;
  } frec_t;

  localparam int NVEC = 22;
  vec_t  vecs [NVEC];
  frec_t exp_q [$];
  frec_t model;

  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(input logic r, input logic [2:0] f3, input logic mw,
                              input logic [1:0] a, input logic [31:0] d, input logic clr,
                              input logic [3:0] we, input logic [31:0] wd,
                              input logic mis, input logic ill);
    vec_t v;
    v.rst_n = r; v.f3 = f3; v.mw = mw; v.addr = a; v.data = d; v.clr = clr;
    v.we = we; v.wdata = wd; v.mis = mis; v.ill = ill;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] f3, input logic mw,
                       input logic [1:0] a, input logic [31:0] d, input logic clr);
    rst_n            = r;
    bus.funct3_i     = f3;
    bus.mem_write_i  = mw;
    bus.addr_i       = a;
    bus.store_data_i = d;
    bus.fault_clr_i  = clr;
  endtask

  // Fault-record reference: reset wins, capture overrides clear, otherwise clear drops valid only.
  task automatic model_step(input vec_t v);
    if (!v.rst_n) begin
      model = '{valid: 1'b0, cause: 1'b0, f3: 3'b000, addr: 2'b00};
    end else if ((v.mis || v.ill) && (!model.valid || v.clr)) begin
      model = '{valid: 1'b1, cause: v.ill, f3: v.f3, addr: v.addr};
    end else if (v.clr) begin
      model.valid = 1'b0;
    end
    exp_q.push_back(model);
  endtask

  task automatic check_fault(input string tag);
    frec_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue: got empty expected entry", tag);
      return;
    end
    checks--;
    e = exp_q.pop_front();
    check({tag, "_fault"},  32'(bus.fault_o),        32'(e.valid));
    check({tag, "_cause"},  32'(bus.fault_cause_o),  32'(e.cause));
    check({tag, "_funct3"}, 32'(bus.fault_funct3_o), 32'(e.f3));
    check({tag, "_addr"},   32'(bus.fault_addr_o),   32'(e.addr));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    drive(v.rst_n, v.f3, v.mw, v.addr, v.data, v.clr);
    #1;
    check({tag, "_we"},    32'(bus.write_en_o),   32'(v.we));
    check({tag, "_wdata"}, bus.mem_wdata_o,       v.wdata);
    check({tag, "_mis"},   32'(bus.misaligned_o), 32'(v.mis));
    check({tag, "_ill"},   32'(bus.illegal_o),    32'(v.ill));
    model_step(v);
    @(posedge clk);
    #1;
    check_fault(tag);
  endtask

  initial begin
    model = '{valid: 1'b0, cause: 1'b0, f3: 3'b000, addr: 2'b00};
    drive(1'b0, 3'b000, 1'b0, 2'b00, 32'h0, 1'b0);

    //            rst  f3      mw  addr   data          clr   we       wdata         mis ill
    vecs[0]  = mk(0, 3'b010, 1, 2'b00, 32'h11223344, 0, 4'b0000, 32'h11223344, 0, 0);
    vecs[1]  = mk(1, 3'b010, 0, 2'b00, 32'h11223344, 0, 4'b0000, 32'h11223344, 0, 0);
    vecs[2]  = mk(1, 3'b010, 1, 2'b00, 32'h11223344, 0, 4'b1111, 32'h11223344, 0, 0);
    vecs[3]  = mk(1, 3'b000, 1, 2'b00, 32'h123456AB, 0, 4'b0001, 32'hABABABAB, 0, 0);
    vecs[4]  = mk(1, 3'b000, 1, 2'b01, 32'h123456AB, 0, 4'b0010, 32'hABABABAB, 0, 0);
    vecs[5]  = mk(1, 3'b000, 1, 2'b10, 32'h123456AB, 0, 4'b0100, 32'hABABABAB, 0, 0);
    vecs[6]  = mk(1, 3'b000, 1, 2'b11, 32'h123456AB, 0, 4'b1000, 32'hABABABAB, 0, 0);
    vecs[7]  = mk(1, 3'b000, 0, 2'b10, 32'h123456AB, 0, 4'b0000, 32'hABABABAB, 0, 0);
    vecs[8]  = mk(1, 3'b001, 1, 2'b00, 32'hDEADBEEF, 0, 4'b0011, 32'hBEEFBEEF, 0, 0);
    vecs[9]  = mk(1, 3'b001, 1, 2'b10, 32'hDEADBEEF, 0, 4'b1100, 32'hBEEFBEEF, 0, 0);
    vecs[10] = mk(1, 3'b001, 1, 2'b01, 32'hDEADBEEF, 0, 4'b0000, 32'hBEEFBEEF, 1, 0);
    vecs[11] = mk(1, 3'b001, 1, 2'b11, 32'hDEADBEEF, 0, 4'b0000, 32'hBEEFBEEF, 1, 0);
    vecs[12] = mk(1, 3'b000, 1, 2'b01, 32'h000000C3, 1, 4'b0010, 32'hC3C3C3C3, 0, 0);
    vecs[13] = mk(1, 3'b010, 1, 2'b01, 32'hA5A5_0F0F, 0, 4'b0000, 32'hA5A50F0F, 1, 0);
    vecs[14] = mk(1, 3'b000, 1, 2'b11, 32'h00000077, 0, 4'b1000, 32'h77777777, 0, 0);
    vecs[15] = mk(1, 3'b000, 1, 2'b00, 32'h00000000, 1, 4'b0001, 32'h00000000, 0, 0);
    vecs[16] = mk(1, 3'b011, 1, 2'b10, 32'hCAFEF00D, 0, 4'b0000, 32'hCAFEF00D, 0, 1);
    vecs[17] = mk(1, 3'b001, 1, 2'b11, 32'h00001234, 1, 4'b0000, 32'h12341234, 1, 0);
    vecs[18] = mk(1, 3'b111, 0, 2'b00, 32'h55AA00FF, 0, 4'b0000, 32'h55AA00FF, 0, 0);
    vecs[19] = mk(1, 3'b100, 1, 2'b01, 32'h00000000, 0, 4'b0000, 32'h00000000, 0, 1);
    vecs[20] = mk(0, 3'b010, 1, 2'b01, 32'h00000000, 0, 4'b0000, 32'h00000000, 0, 0);
    vecs[21] = mk(1, 3'b010, 1, 2'b00, 32'h89ABCDEF, 0, 4'b1111, 32'h89ABCDEF, 0, 0);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Misaligned SW followed by a clean SB: record appears one cycle later and is not overwritten.
    @(negedge clk);
    drive(1'b1, 3'b010, 1'b1, 2'b01, 32'h0BADF00D, 1'b0);
    #1;
    check("seq_sw_we",  32'(bus.write_en_o),   32'h0);
    check("seq_sw_mis", 32'(bus.misaligned_o), 32'h1);
    check("seq_pre_fault", 32'(bus.fault_o),   32'h0);
    @(negedge clk);
    check("seq_fault",  32'(bus.fault_o),        32'h1);
    check("seq_cause",  32'(bus.fault_cause_o),  32'h0);
    check("seq_funct3", 32'(bus.fault_funct3_o), 32'h2);
    check("seq_addr",   32'(bus.fault_addr_o),   32'h1);
    drive(1'b1, 3'b000, 1'b1, 2'b10, 32'h0000005A, 1'b0);
    #1;
    check("seq_sb_we",    32'(bus.write_en_o),  32'h4);
    check("seq_sb_wdata", bus.mem_wdata_o,      32'h5A5A5A5A);
    @(negedge clk);
    check("seq_keep_fault",  32'(bus.fault_o),        32'h1);
    check("seq_keep_funct3", 32'(bus.fault_funct3_o), 32'h2);
    check("seq_keep_addr",   32'(bus.fault_addr_o),   32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_unit.md
# store_unit

Store-path byte-lane unit between the execute stage and the 32-bit data memory of the RV32 core. For SB/SH/SW it decodes funct3 and the two low address bits into a 4-bit byte write enable and replicates the store data onto the correct lanes. It flags misaligned and unsupported stores combinationally. A registered sticky fault record captures the first offending store for the trap logic.

## Interface
Parameters: none. funct3 encodings are fixed constants in `store_pkg` (see Structure).

Clocking and reset: one clock; reset is synchronous and active-low.

Ports:
- `clk_i` input 1: single clock, rising edge.
- `rst_ni` input 1: synchronous, active-low reset.
- `funct3_i` input 3: store width code. SB=3'b000, SH=3'b001, SW=3'b010.
- `mem_write_i` input 1: a store is requested this cycle.
- `addr_i` input 2: byte offset, address bits [1:0].
- `store_data_i` input 32: rs2 value.
- `fault_clr_i` input 1: clears the sticky fault record.
- `write_en_o` output 4: byte write enable; bit n enables byte lane n, i.e. data bits [8n+7:8n].
- `mem_wdata_o` output 32: lane-aligned write data.
- `misaligned_o` output 1: current store is misaligned.
- `illegal_o` output 1: current store has an unsupported funct3.
- `fault_o` output 1: sticky fault valid.
- `fault_cause_o` output 1: 0 = misaligned, 1 = illegal.
- `fault_funct3_o` output 3: captured funct3.
- `fault_addr_o` output 2: captured offset.

## Operation
- If `mem_write_i`=0, then `write_en_o`=4'b0000, `misaligned_o`=0 and `illegal_o`=0.
- SB: `write_en_o` = 4'b0001 << `addr_i`, so offsets 00/01/10/11 give 0001/0010/0100/1000. Never misaligned.
- SH:
  - offset 00 gives 0011.
  - offset 10 gives 1100.
  - offsets 01 and 11 give 0000 and assert `misaligned_o`.
- SW:
  - offset 00 gives 1111.
  - any other offset gives 0000 and asserts `misaligned_o`.
- Any other funct3 with `mem_write_i`=1: `write_en_o`=0000 and `illegal_o`=1.
- `misaligned_o` and `illegal_o` are never both 1.
- `mem_wdata_o` depends only on funct3; it is independent of `addr_i` and `mem_write_i`:
  - SB: the low byte of `store_data_i` replicated into all 4 lanes.
  - SH: the low half of `store_data_i` replicated into both halves.
  - SW and all other codes: `store_data_i` unchanged.
- Fault record:
  - Captures on a rising edge when `fault_o`=0, `mem_write_i`=1 and (`misaligned_o` or `illegal_o`).
  - Capture sets `fault_o`=1 and loads cause, funct3 and addr.
  - While `fault_o`=1, further faults do not overwrite the record; the first fault is kept.
  - `fault_clr_i`=1 at an edge clears `fault_o`. Cause/funct3/addr keep their stale values.
  - If clear and a new fault occur at the same edge, the new fault is captured (set wins), so no event is lost.

## Timing
- `write_en_o`, `mem_wdata_o`, `misaligned_o` and `illegal_o` are purely combinational: zero-cycle latency, valid in the same cycle as the inputs.
- Fault record: one-cycle latency; `fault_o` is visible in the cycle after the offending store.
- Reset, while `rst_ni`=0:
  - `write_en_o` is forced to 0000.
  - `misaligned_o` and `illegal_o` are forced to 0.
  - At the edge: `fault_o`=0, `fault_cause_o`=0, `fault_funct3_o`=3'b000, `fault_addr_o`=2'b00.
  - `mem_wdata_o` still follows its inputs.
- Reset asserted in the same cycle as an offending store: reset wins, nothing is captured.
- No handshake: the memory samples `write_en_o` and `mem_wdata_o` on its own clock edge.

## Structure
- `store_pkg`: localparams `FUNCT3_SB`, `FUNCT3_SH`, `FUNCT3_SW`, and `CAUSE_MISALIGNED`=1'b0 / `CAUSE_ILLEGAL`=1'b1. The load unit shares this package.
- Sub-module `store_be_decode`: combinational decode of funct3/addr/mem_write to `write_en`, `misaligned` and `illegal`.
- The top level adds data replication, reset gating and the fault register.

## Test plan
- SW with `mem_write_i`=0, addr 00 -> `write_en_o`=0000, no flags. SW with `mem_write_i`=1, addr 00 -> 1111, `mem_wdata_o`=`store_data_i`.
- SB with `mem_write_i`=1, addr 00..11 -> 0001, 0010, 0100, 1000. `store_data_i`=32'h123456AB -> `mem_wdata_o`=32'hABABABAB. With `mem_write_i`=0 -> 0000.
- SH with `mem_write_i`=1:
  - addr 00 -> 0011; addr 10 -> 1100.
  - addr 01 and 11 -> 0000 with `misaligned_o`=1.
  - `store_data_i`=32'hDEADBEEF -> `mem_wdata_o`=32'hBEEFBEEF.
- SW with `mem_write_i`=1, addr 01 -> 0000, `misaligned_o`=1; next cycle `fault_o`=1, cause 0, funct3 010, addr 01. A following SB is unaffected and does not overwrite the record.
- funct3=3'b011 with `mem_write_i`=1 -> 0000, `illegal_o`=1; captured with cause 1. Then `fault_clr_i`=1 together with a new misaligned SH -> `fault_o` stays 1 with cause 0 and addr of the SH.
- Assert `rst_ni`=0 while SW addr 00 is driven -> `write_en_o`=0000 and `fault_o`=0 after the edge. Release reset -> 1111 in the same cycle.
